// File: rtl/mano_pkg.sv
// Shared encodings for the basic-computer control unit: bus sources, ALU ops,
// opcode indices and the sequencer state type.
package mano_pkg;

  localparam int SC_W = 3;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_sel_t;

  typedef enum logic [1:0] {
    ALU_AND     = 2'd0,
    ALU_ADD     = 2'd1,
    ALU_PASS_DR = 2'd2
  } alu_op_t;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam int OP_AND = 0;
  localparam int OP_ADD = 1;
  localparam int OP_LDA = 2;
  localparam int OP_STA = 3;
  localparam int OP_BUN = 4;
  localparam int OP_BSA = 5;
  localparam int OP_ISZ = 6;
  localparam int OP_REG = 7;

  function automatic logic [7:0] decode_op(input logic [2:0] op);
    decode_op = 8'd1 << op;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter with increment/clear and its one-hot T0..T7 decode.
module mano_seq_counter
  import mano_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] t
);

  localparam logic [SC_W-1:0] SC_MAX = '1;

  logic [SC_W-1:0] sc;

  // The top value is never a legal timing step, so it always wraps to T0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
    end else if (clr || sc == SC_MAX) begin
      sc <= '0;
    end else if (inc) begin
      sc <= sc + 1'b1;
    end
  end

  always_comb begin
    t = 8'd1 << sc;
  end

endmodule

// File: rtl/mano_ctrl_sequencer.sv
// Control unit of the basic computer: HALT/RUN sequencing, I/D latches and
// the per-timing-step strobe decode for the AR/PC/IR/DR/AC datapath.
module mano_ctrl_sequencer
  import mano_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] ir,
  input  logic              dr_zero,
  input  logic              ac_sign,
  input  logic              ac_zero,
  input  logic              e_zero,
  output logic [7:0]        t,
  output logic [7:0]        d,
  output logic [2:0]        bus_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              ar_ld,
  output logic              ar_inc,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              ir_ld,
  output logic              dr_ld,
  output logic              dr_inc,
  output logic              ac_ld,
  output logic [1:0]        alu_op,
  output logic [11:0]       rr_en,
  output logic              halted
);

  seq_state_t state_q, state_d;
  logic       ind_q;
  logic [7:0] d_q;
  logic [7:0] t_raw;
  logic       running;
  logic       sc_clr;
  logic       skip;
  bus_sel_t   bus;
  alu_op_t    alu;

  assign running = (state_q == ST_RUN);

  mano_seq_counter u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .inc   (running),
    .t     (t_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      ind_q   <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      if (running && t_raw[2]) begin
        ind_q <= ir[WORD_W-1];
        d_q   <= decode_op(ir[WORD_W-2 -: 3]);
      end
    end
  end

  assign skip = (ir[4] & ~ac_sign) | (ir[3] & ac_sign) |
                (ir[2] & ac_zero)  | (ir[1] & e_zero);

  // Every strobe is qualified by RUN, so HALT and reset leave the datapath idle.
  always_comb begin
    state_d = state_q;
    sc_clr  = 1'b0;
    bus     = BUS_NONE;
    alu     = ALU_AND;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ar_ld   = 1'b0;
    ar_inc  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ac_ld   = 1'b0;
    rr_en   = '0;

    if (!running) begin
      sc_clr = 1'b1;
      if (start) state_d = ST_RUN;
    end else if (t_raw[0]) begin
      bus   = BUS_PC;
      ar_ld = 1'b1;
    end else if (t_raw[1]) begin
      bus    = BUS_MEM;
      mem_rd = 1'b1;
      ir_ld  = 1'b1;
      pc_inc = 1'b1;
    end else if (t_raw[2]) begin
      bus   = BUS_IR;
      ar_ld = 1'b1;
    end else if (t_raw[3]) begin
      if (!d_q[OP_REG]) begin
        if (ind_q) begin
          bus    = BUS_MEM;
          mem_rd = 1'b1;
          ar_ld  = 1'b1;
        end
      end else begin
        sc_clr = 1'b1;
        if (!ind_q) begin
          rr_en  = ir[11:0];
          pc_inc = skip;
          if (ir[0]) state_d = ST_HALT;
        end
      end
    end else if (t_raw[4]) begin
      if (d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA] | d_q[OP_ISZ]) begin
        bus    = BUS_MEM;
        mem_rd = 1'b1;
        dr_ld  = 1'b1;
      end else if (d_q[OP_STA]) begin
        bus    = BUS_AC;
        mem_wr = 1'b1;
        sc_clr = 1'b1;
      end else if (d_q[OP_BUN]) begin
        bus    = BUS_AR;
        pc_ld  = 1'b1;
        sc_clr = 1'b1;
      end else if (d_q[OP_BSA]) begin
        bus    = BUS_PC;
        mem_wr = 1'b1;
        ar_inc = 1'b1;
      end else begin
        sc_clr = 1'b1;
      end
    end else if (t_raw[5]) begin
      if (d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA]) begin
        ac_ld  = 1'b1;
        alu    = d_q[OP_AND] ? ALU_AND : (d_q[OP_ADD] ? ALU_ADD : ALU_PASS_DR);
        sc_clr = 1'b1;
      end else if (d_q[OP_BSA]) begin
        bus    = BUS_AR;
        pc_ld  = 1'b1;
        sc_clr = 1'b1;
      end else if (d_q[OP_ISZ]) begin
        dr_inc = 1'b1;
      end else begin
        sc_clr = 1'b1;
      end
    end else begin
      // T6 only carries ISZ write-back; T6/T7 always close the instruction.
      sc_clr = 1'b1;
      if (t_raw[6] && d_q[OP_ISZ]) begin
        bus    = BUS_DR;
        mem_wr = 1'b1;
        pc_inc = dr_zero;
      end
    end
  end

  assign t       = running ? t_raw : 8'd0;
  assign d       = running ? d_q : 8'd0;
  assign halted  = ~running;
  assign bus_sel = bus;
  assign alu_op  = alu;

endmodule

// File: tb/tb_mano_ctrl_sequencer.sv
// Directed, table-driven check of the control sequencer: fetch, each
// instruction class, skips, HLT and reset during an instruction.
module tb_mano_ctrl_sequencer;

  localparam logic [9:0] MRD = 10'h200;
  localparam logic [9:0] MWR = 10'h100;
  localparam logic [9:0] ARL = 10'h080;
  localparam logic [9:0] ARI = 10'h040;
  localparam logic [9:0] PCL = 10'h020;
  localparam logic [9:0] PCI = 10'h010;
  localparam logic [9:0] IRL = 10'h008;
  localparam logic [9:0] DRL = 10'h004;
  localparam logic [9:0] DRI = 10'h002;
  localparam logic [9:0] ACL = 10'h001;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        start;
    logic [15:0] ir;
    logic [3:0]  flg;
    logic [43:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir;
  logic        dr_zero, ac_sign, ac_zero, e_zero;
  logic [7:0]  t, d;
  logic [2:0]  bus_sel;
  logic        mem_rd, mem_wr, ar_ld, ar_inc, pc_ld, pc_inc;
  logic        ir_ld, dr_ld, dr_inc, ac_ld;
  logic [1:0]  alu_op;
  logic [11:0] rr_en;
  logic        halted;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  mano_ctrl_sequencer #(.WORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
    .dr_zero(dr_zero), .ac_sign(ac_sign), .ac_zero(ac_zero), .e_zero(e_zero),
    .t(t), .d(d), .bus_sel(bus_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .ir_ld(ir_ld), .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld),
    .alu_op(alu_op), .rr_en(rr_en), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] pack(input logic [7:0] et, input logic [7:0] ed,
                                       input logic [2:0] eb, input logic [9:0] es,
                                       input logic [1:0] ea, input logic [11:0] er,
                                       input logic eh);
    pack = {et, ed, eb, es, ea, er, eh};
  endfunction

  task automatic add(input string nm, input logic r, input logic s, input logic [15:0] i,
                     input logic [3:0] f, input logic [7:0] et, input logic [7:0] ed,
                     input logic [2:0] eb, input logic [9:0] es, input logic [1:0] ea,
                     input logic [11:0] er, input logic eh);
    vec_t v;
    v.name = nm; v.rst_n = r; v.start = s; v.ir = i; v.flg = f;
    v.exp  = pack(et, ed, eb, es, ea, er, eh);
    vecs.push_back(v);
  endtask

  // T0..T2 of a fetch; the shown D is whatever the previous instruction left.
  task automatic add_fetch(input string nm, input logic [15:0] i, input logic [3:0] f,
                           input logic [7:0] ed);
    add({nm, "_t0"}, 1, 0, i, f, 8'h01, ed, 3'd2, ARL, 0, 0, 0);
    add({nm, "_t1"}, 1, 0, i, f, 8'h02, ed, 3'd7, MRD | IRL | PCI, 0, 0, 0);
    add({nm, "_t2"}, 1, 0, i, f, 8'h04, ed, 3'd5, ARL, 0, 0, 0);
  endtask

  task automatic checkOutput(input string nm, input logic [43:0] exp);
    logic [43:0] act;
    act = {t, d, bus_sel, mem_rd, mem_wr, ar_ld, ar_inc, pc_ld, pc_inc,
           ir_ld, dr_ld, dr_inc, ac_ld, alu_op, rr_en, halted};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got t=%h d=%h bus=%0d str=%b alu=%0d rr=%h h=%b, want t=%h d=%h bus=%0d str=%b alu=%0d rr=%h h=%b",
               nm, act[43:36], act[35:28], act[27:25], act[24:15], act[14:13], act[12:1], act[0],
               exp[43:36], exp[35:28], exp[27:25], exp[24:15], exp[14:13], exp[12:1], exp[0]);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n;
    start = v.start;
    ir    = v.ir;
    {dr_zero, ac_sign, ac_zero, e_zero} = v.flg;
    #1;
    checkOutput(v.name, v.exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ir = '0;
    {dr_zero, ac_sign, ac_zero, e_zero} = 4'b0;

    add("rst_hold", 0, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add("rst_hold2", 0, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add("idle", 1, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add("start", 1, 1, 16'h2005, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    // LDA direct; start is raised at T3 and must be ignored.
    add_fetch("lda", 16'h2005, 0, 8'h00);
    add("lda_t3", 1, 1, 16'h2005, 0, 8'h08, 8'h04, 0, 0, 0, 0, 0);
    add("lda_t4", 1, 0, 16'h2005, 0, 8'h10, 8'h04, 7, MRD | DRL, 0, 0, 0);
    add("lda_t5", 1, 0, 16'h2005, 0, 8'h20, 8'h04, 0, ACL, 2, 0, 0);
    // BUN indirect: five cycles.
    add_fetch("bun", 16'hC010, 0, 8'h04);
    add("bun_t3", 1, 0, 16'hC010, 0, 8'h08, 8'h10, 7, MRD | ARL, 0, 0, 0);
    add("bun_t4", 1, 0, 16'hC010, 0, 8'h10, 8'h10, 1, PCL, 0, 0, 0);
    // ISZ with DR reaching zero, then without.
    add_fetch("isz", 16'h6020, 4'b1000, 8'h10);
    add("isz_t3", 1, 0, 16'h6020, 4'b1000, 8'h08, 8'h40, 0, 0, 0, 0, 0);
    add("isz_t4", 1, 0, 16'h6020, 4'b1000, 8'h10, 8'h40, 7, MRD | DRL, 0, 0, 0);
    add("isz_t5", 1, 0, 16'h6020, 4'b1000, 8'h20, 8'h40, 0, DRI, 0, 0, 0);
    add("isz_t6", 1, 0, 16'h6020, 4'b1000, 8'h40, 8'h40, 3, MWR | PCI, 0, 0, 0);
    add_fetch("isz2", 16'h6020, 0, 8'h40);
    add("isz2_t3", 1, 0, 16'h6020, 0, 8'h08, 8'h40, 0, 0, 0, 0, 0);
    add("isz2_t4", 1, 0, 16'h6020, 0, 8'h10, 8'h40, 7, MRD | DRL, 0, 0, 0);
    add("isz2_t5", 1, 0, 16'h6020, 0, 8'h20, 8'h40, 0, DRI, 0, 0, 0);
    add("isz2_t6", 1, 0, 16'h6020, 0, 8'h40, 8'h40, 3, MWR, 0, 0, 0);
    // Register-reference skips.
    add_fetch("spa", 16'h7010, 0, 8'h40);
    add("spa_t3", 1, 0, 16'h7010, 0, 8'h08, 8'h80, 0, PCI, 0, 12'h010, 0);
    add_fetch("sna", 16'h7008, 0, 8'h80);
    add("sna_t3", 1, 0, 16'h7008, 0, 8'h08, 8'h80, 0, 0, 0, 12'h008, 0);
    add_fetch("sza", 16'h7004, 4'b0010, 8'h80);
    add("sza_t3", 1, 0, 16'h7004, 4'b0010, 8'h08, 8'h80, 0, PCI, 0, 12'h004, 0);
    // HLT, then restart into BSA.
    add_fetch("hlt", 16'h7001, 0, 8'h80);
    add("hlt_t3", 1, 0, 16'h7001, 0, 8'h08, 8'h80, 0, 0, 0, 12'h001, 0);
    add("hlt_after", 1, 0, 16'h5030, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add("restart", 1, 1, 16'h5030, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add_fetch("bsa", 16'h5030, 0, 8'h80);
    add("bsa_t3", 1, 0, 16'h5030, 0, 8'h08, 8'h20, 0, 0, 0, 0, 0);
    add("bsa_t4", 1, 0, 16'h5030, 0, 8'h10, 8'h20, 2, MWR | ARI, 0, 0, 0);
    add("bsa_t5", 1, 0, 16'h5030, 0, 8'h20, 8'h20, 1, PCL, 0, 0, 0);
    add_fetch("bsa2", 16'h5030, 0, 8'h20);
    add("bsa2_t3", 1, 0, 16'h5030, 0, 8'h08, 8'h20, 0, 0, 0, 0, 0);
    add("bsa2_t4", 1, 0, 16'h5030, 0, 8'h10, 8'h20, 2, MWR | ARI, 0, 0, 0);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Reset asserted in the middle of BSA T4, before the clock edge.
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_mid_t4", pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
    @(negedge clk);
    #1 checkOutput("rst_mid_hold", pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("post_rst_idle%0d", c), pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 checkOutput("post_rst_t0", pack(8'h01, 8'h00, 3'd2, ARL, 0, 0, 0));
    @(negedge clk);
    #1 checkOutput("post_rst_t1", pack(8'h02, 8'h00, 3'd7, MRD | IRL | PCI, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
